mem_request_unit: RTL and testbench

//  Requester side of the banked data-memory stage. Accepts load/store ops from execute through a small FIFO.

---
 rtl/mem_request_unit_if.sv | 35 +++
 rtl/mem_request_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_request_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_unit_if.sv
// Signal bundle between execute/writeback, the request unit and the banked data memory.
// The unit itself sits on the slave side; the surrounding pipeline and memory drive the master side.
interface mem_request_unit_if #(
  parameter int unsigned TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [63:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             mem_interlock;
  logic [31:0]      mem_addr;
  logic [63:0]      mem_dina;
  logic [7:0]       mem_wea;
  logic [63:0]      mem_rdata;
  logic             rsp_valid;
  logic [63:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             err_misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    output mem_interlock, mem_rdata,
    input  req_ready, mem_addr, mem_dina, mem_wea, rsp_valid, rsp_data, rsp_tag, err_misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    input  mem_interlock, mem_rdata,
    output req_ready, mem_addr, mem_dina, mem_wea, rsp_valid, rsp_data, rsp_tag, err_misalign
  );
endinterface

// File: rtl/mem_request_unit.sv
// Requester side of the banked data-memory stage: request FIFO, one memory access per unstalled
// cycle, latency-matched load tag pipe and load data alignment/extension toward writeback.
module mem_request_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LAT        = 3,
  parameter int unsigned TAG_W      = 5
) (
  input logic               clk,
  input logic               rstn,
  mem_request_unit_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  // An entry occupies the last stage during the cycle its word is on mem_rdata.
  localparam int unsigned PipeN = LAT + 1;

  typedef struct packed {
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [31:0]      addr;
    logic [63:0]      wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       size;
    logic             uns;
    logic [2:0]       off;
  } tag_t;

  req_t            fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q;
  logic            push, pop;
  req_t            in_req, head;

  logic             misalign;
  logic [7:0]       size_mask;
  logic             issue_load, issue_store;
  logic [7:0]       wea_next;
  logic [63:0]      dina_next;
  tag_t             new_entry;
  tag_t             pipe_q [PipeN];
  tag_t             last;
  logic [63:0]      shifted, ext_data;

  logic [31:0]      addr_q;
  logic [63:0]      dina_q;
  logic [7:0]       wea_q;
  logic             err_q;
  logic             rsp_valid_q;
  logic [63:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;

  assign push = bus.req_valid & ready_q;
  assign pop  = ~bus.mem_interlock & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    in_req       = '0;
    in_req.we    = bus.req_we;
    in_req.size  = bus.req_size;
    in_req.uns   = bus.req_unsigned;
    in_req.addr  = bus.req_addr;
    in_req.wdata = bus.req_wdata;
    in_req.tag   = bus.req_tag;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CntW'(FIFO_DEPTH));
    end
  end

  // Issue decode for the FIFO head.
  always_comb begin
    misalign  = 1'b0;
    size_mask = 8'h01;
    unique case (head.size)
      2'd0: begin misalign = 1'b0;              size_mask = 8'h01; end
      2'd1: begin misalign = head.addr[0];      size_mask = 8'h03; end
      2'd2: begin misalign = |head.addr[1:0];   size_mask = 8'h0F; end
      2'd3: begin misalign = |head.addr[2:0];   size_mask = 8'hFF; end
    endcase
    issue_load  = pop & ~head.we & ~misalign;
    issue_store = pop & head.we & ~misalign;
    wea_next    = size_mask << head.addr[2:0];
    dina_next   = head.wdata << {head.addr[2:0], 3'b000};
    new_entry   = '0;
    if (issue_load) begin
      new_entry.valid = 1'b1;
      new_entry.tag   = head.tag;
      new_entry.size  = head.size;
      new_entry.uns   = head.uns;
      new_entry.off   = head.addr[2:0];
    end
  end

  always_comb begin
    last     = pipe_q[PipeN-1];
    shifted  = bus.mem_rdata >> {last.off, 3'b000};
    ext_data = shifted;
    unique case (last.size)
      2'd0: ext_data = last.uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: ext_data = last.uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: ext_data = last.uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: ext_data = shifted;
    endcase
  end

  // A stalled edge freezes the access registers and the tag pipe; pulses drop back to 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q      <= '0;
      dina_q      <= '0;
      wea_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      for (int k = 0; k < PipeN; k++) pipe_q[k] <= '0;
    end else if (bus.mem_interlock) begin
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      err_q <= pop & misalign;
      wea_q <= issue_store ? wea_next : 8'h00;
      if (pop)         addr_q <= {3'b000, head.addr[31:3]};
      if (issue_store) dina_q <= dina_next;
      pipe_q[0] <= new_entry;
      for (int k = 1; k < PipeN; k++) pipe_q[k] <= pipe_q[k-1];
      rsp_valid_q <= last.valid;
      if (last.valid) begin
        rsp_data_q <= ext_data;
        rsp_tag_q  <= last.tag;
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_dina     = dina_q;
  // A store held across a stall must still write once the stall lifts.
  assign bus.mem_wea      = bus.mem_interlock ? 8'h00 : wea_q;
  assign bus.err_misalign = err_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_tag      = rsp_tag_q;
endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a LAT-deep, interlock-aware data-memory model.
module tb_mem_request_unit;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LAT        = 3;
  localparam int unsigned TAG_W      = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   acc   = 0;

  mem_request_unit_if #(.TAG_W(TAG_W)) bus ();

  mem_request_unit #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .LAT       (LAT),
    .TAG_W     (TAG_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: writes and reads take effect only on unstalled edges; word returns LAT cycles later.
  logic [63:0] mem_model [64];
  logic [63:0] rd_pipe [LAT];
  assign bus.mem_rdata = rd_pipe[LAT-1];
  always @(posedge clk) begin
    if (!bus.mem_interlock) begin
      for (int b = 0; b < 8; b++)
        if (bus.mem_wea[b]) mem_model[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_dina[8*b +: 8];
      rd_pipe[0] <= mem_model[bus.mem_addr[5:0]];
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_tag      = '0;
  endtask

  // Offers one request; returns at the negedge following its acceptance edge (acc = that edge).
  task automatic enq(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [TAG_W-1:0] tag);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_tag      = tag;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready === 1'b1) begin
        @(negedge clk);
        acc = cyc;
        drive_idle();
        return;
      end
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL enq_timeout: req_ready=%b, required 1", bus.req_ready);
    drive_idle();
  endtask

  task automatic wait_rsp(output logic got, output int at, output logic [63:0] data,
                          output logic [TAG_W-1:0] tag);
    got = 1'b0; at = -1; data = '0; tag = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1; at = cyc; data = bus.rsp_data; tag = bus.rsp_tag;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_idle();
    bus.mem_interlock = 1'b0;
    idle(3);
    rstn = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.mem_wea !== 8'h00)   begin bad++; $display("FAIL rst_wea: got %h want 00", bus.mem_wea); end
    total++; if (bus.mem_addr !== 32'h0)  begin bad++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_dina !== 64'h0)  begin bad++; $display("FAIL rst_dina: got %h want 0", bus.mem_dina); end
    total++; if (bus.rsp_valid !== 1'b0)  begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 64'h0)  begin bad++; $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); end
    total++; if (bus.rsp_tag !== '0)      begin bad++; $display("FAIL rst_rsp_tag: got %h want 0", bus.rsp_tag); end
    total++; if (bus.err_misalign !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err_misalign); end
  endtask

  task automatic test_store();
    logic [1:0]  sz [6]  = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd3};
    logic [31:0] ad [6]  = '{32'h104, 32'h105, 32'h10A, 32'h8, 32'h0, 32'h100};
    logic [63:0] wd [6]  = '{64'hDEADBEEF, 64'hAB, 64'hBEEF, 64'h0123_4567_89AB_CDEF,
                             64'h1111_2222_8333_4444, 64'h80AB_CDEF_0123_4567};
    logic [31:0] ea [6]  = '{32'h20, 32'h20, 32'h21, 32'h1, 32'h0, 32'h20};
    logic [7:0]  ew [6]  = '{8'hF0, 8'h20, 8'h0C, 8'hFF, 8'hFF, 8'hFF};
    logic [63:0] ed [6]  = '{64'hDEADBEEF_0000_0000, 64'h0000_AB00_0000_0000,
                             64'h0000_0000_BEEF_0000, 64'h0123_4567_89AB_CDEF,
                             64'h1111_2222_8333_4444, 64'h80AB_CDEF_0123_4567};
    for (int i = 0; i < 6; i++) begin
      enq(1'b1, sz[i], 1'b0, ad[i], wd[i], '0);
      @(negedge clk);
      total++; if (bus.mem_addr !== ea[i]) begin bad++; $display("FAIL st%0d_addr: got %h want %h", i, bus.mem_addr, ea[i]); end
      total++; if (bus.mem_wea !== ew[i])  begin bad++; $display("FAIL st%0d_wea: got %h want %h", i, bus.mem_wea, ew[i]); end
      total++; if (bus.mem_dina !== ed[i]) begin bad++; $display("FAIL st%0d_dina: got %h want %h", i, bus.mem_dina, ed[i]); end
    end
    @(negedge clk);
    total++; if (bus.mem_wea !== 8'h00) begin bad++; $display("FAIL st_idle_wea: got %h want 00", bus.mem_wea); end
  endtask

  task automatic test_load_extend();
    logic [1:0]       sz [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic             un [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0]      ad [7] = '{32'h107, 32'h107, 32'h106, 32'h10A, 32'h0, 32'h0, 32'h8};
    logic [TAG_W-1:0] tg [7] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    logic [63:0]      ex [7] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_80AB,
                                 64'hBEEF, 64'hFFFF_FFFF_8333_4444, 64'h8333_4444,
                                 64'h0123_4567_89AB_CDEF};
    logic got; int at; logic [63:0] d; logic [TAG_W-1:0] t;
    for (int i = 0; i < 7; i++) begin
      enq(1'b0, sz[i], un[i], ad[i], '0, tg[i]);
      wait_rsp(got, at, d, t);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL ld%0d_valid: got %b want 1", i, got); end
      total++; if (at !== acc + int'(LAT) + 2) begin bad++; $display("FAIL ld%0d_latency: got cycle %0d want %0d", i, at, acc + int'(LAT) + 2); end
      total++; if (d !== ex[i]) begin bad++; $display("FAIL ld%0d_data: got %h want %h", i, d, ex[i]); end
      total++; if (t !== tg[i]) begin bad++; $display("FAIL ld%0d_tag: got %0d want %0d", i, t, tg[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int          exp_at [3];
    logic [63:0] exp_d  [3] = '{64'hFFFF_FFFF_8333_4444, 64'h1111_2222, 64'h0123_4567_89AB_CDEF};
    logic [TAG_W-1:0] exp_t [3] = '{5'd10, 5'd11, 5'd12};
    logic got; int at; logic [63:0] d; logic [TAG_W-1:0] t; int l;
    enq(1'b0, 2'd2, 1'b0, 32'h0, '0, 5'd10);
    enq(1'b0, 2'd2, 1'b0, 32'h4, '0, 5'd11);
    enq(1'b1, 2'd3, 1'b0, 32'h18, 64'h5555_AAAA_0000_FFFF, '0);
    enq(1'b0, 2'd3, 1'b0, 32'h8, '0, 5'd12);
    l = acc;
    // Stall the two edges after the final accept; the SD is on the mem_* outputs meanwhile.
    bus.mem_interlock = 1'b1;
    #1;
    total++; if (bus.mem_wea !== 8'h00) begin bad++; $display("FAIL b2b_wea_stall0: got %h want 00", bus.mem_wea); end
    @(negedge clk);
    #1;
    total++; if (bus.mem_wea !== 8'h00) begin bad++; $display("FAIL b2b_wea_stall1: got %h want 00", bus.mem_wea); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_rsp_stall: got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    bus.mem_interlock = 1'b0;
    #1;
    total++; if (bus.mem_wea !== 8'hFF) begin bad++; $display("FAIL b2b_wea_release: got %h want FF", bus.mem_wea); end
    exp_at[0] = l + 4; exp_at[1] = l + 5; exp_at[2] = l + 7;
    for (int i = 0; i < 3; i++) begin
      wait_rsp(got, at, d, t);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid: got %b want 1", i, got); end
      total++; if (at !== exp_at[i]) begin bad++; $display("FAIL b2b%0d_cycle: got %0d want %0d", i, at, exp_at[i]); end
      total++; if (d !== exp_d[i]) begin bad++; $display("FAIL b2b%0d_data: got %h want %h", i, d, exp_d[i]); end
      total++; if (t !== exp_t[i]) begin bad++; $display("FAIL b2b%0d_tag: got %0d want %0d", i, t, exp_t[i]); end
    end
  endtask

  task automatic test_fill();
    logic [1:0]       sz [4] = '{2'd3, 2'd2, 2'd0, 2'd3};
    logic [31:0]      ad [4] = '{32'h18, 32'h4, 32'h100, 32'h0};
    logic [TAG_W-1:0] tg [4] = '{5'd13, 5'd14, 5'd15, 5'd16};
    logic [63:0]      ex [4] = '{64'h5555_AAAA_0000_FFFF, 64'h1111_2222, 64'h67,
                                 64'h1111_2222_8333_4444};
    logic got; int at; logic [63:0] d; logic [TAG_W-1:0] t; int f;
    bus.mem_interlock = 1'b1;
    for (int i = 0; i < 4; i++) enq(1'b0, sz[i], 1'b0, ad[i], '0, tg[i]);
    f = acc;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full: got %b want 0", bus.req_ready); end
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_hold: got %b want 0", bus.req_ready); end
    bus.mem_interlock = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_back: got %b want 1", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      wait_rsp(got, at, d, t);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL fill%0d_valid: got %b want 1", i, got); end
      total++; if (at !== f + 6 + i) begin bad++; $display("FAIL fill%0d_cycle: got %0d want %0d", i, at, f + 6 + i); end
      total++; if (d !== ex[i]) begin bad++; $display("FAIL fill%0d_data: got %h want %h", i, d, ex[i]); end
      total++; if (t !== tg[i]) begin bad++; $display("FAIL fill%0d_tag: got %0d want %0d", i, t, tg[i]); end
    end
    wait_rsp(got, at, d, t);
    total++; if (got !== 1'b0) begin bad++; $display("FAIL fill_extra_rsp: got tag %0d, want no response", t); end
  endtask

  task automatic test_misalign();
    logic got; int at; logic [63:0] d; logic [TAG_W-1:0] t; int m;
    enq(1'b0, 2'd1, 1'b0, 32'h3, '0, 5'd17);
    m = acc;
    enq(1'b0, 2'd2, 1'b0, 32'h4, '0, 5'd18);
    total++; if (bus.err_misalign !== 1'b1) begin bad++; $display("FAIL mis_err_pulse: got %b want 1", bus.err_misalign); end
    total++; if (bus.mem_wea !== 8'h00) begin bad++; $display("FAIL mis_wea: got %h want 00", bus.mem_wea); end
    @(negedge clk);
    total++; if (bus.err_misalign !== 1'b0) begin bad++; $display("FAIL mis_err_clear: got %b want 0", bus.err_misalign); end
    wait_rsp(got, at, d, t);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL mis_lw_valid: got %b want 1", got); end
    total++; if (at !== m + 6) begin bad++; $display("FAIL mis_lw_cycle: got %0d want %0d", at, m + 6); end
    total++; if (t !== 5'd18) begin bad++; $display("FAIL mis_lw_tag: got %0d want 18", t); end
    total++; if (d !== 64'h1111_2222) begin bad++; $display("FAIL mis_lw_data: got %h want 1111_2222", d); end
    enq(1'b1, 2'd2, 1'b0, 32'h102, 64'h1234_5678, '0);
    @(negedge clk);
    total++; if (bus.err_misalign !== 1'b1) begin bad++; $display("FAIL mis_sw_err: got %b want 1", bus.err_misalign); end
    total++; if (bus.mem_wea !== 8'h00) begin bad++; $display("FAIL mis_sw_wea: got %h want 00", bus.mem_wea); end
    wait_rsp(got, at, d, t);
    total++; if (got !== 1'b0) begin bad++; $display("FAIL mis_no_rsp: got tag %0d, want no response", t); end
  endtask

  task automatic test_reset_midflight();
    int n_rsp;
    logic got; int at; logic [63:0] d; logic [TAG_W-1:0] t; int r;
    n_rsp = 0;
    enq(1'b0, 2'd3, 1'b0, 32'h0, '0, 5'd20);
    enq(1'b0, 2'd3, 1'b0, 32'h8, '0, 5'd21);
    @(negedge clk);
    bus.mem_interlock = 1'b1;
    for (int i = 0; i < 3; i++) enq(1'b0, 2'd3, 1'b0, 32'h8, '0, 5'(22 + i));
    rstn = 1'b0;
    bus.mem_interlock = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_rsp++;
    end
    rstn = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.mem_wea !== 8'h00) begin bad++; $display("FAIL rmid_wea: got %h want 00", bus.mem_wea); end
    for (int i = 0; i < 14; i++) begin
      if (bus.rsp_valid === 1'b1) n_rsp++;
      @(negedge clk);
    end
    total++; if (n_rsp !== 0) begin bad++; $display("FAIL rmid_rsp: got %0d responses want 0", n_rsp); end
    enq(1'b0, 2'd3, 1'b0, 32'h8, '0, 5'd25);
    r = acc;
    wait_rsp(got, at, d, t);
    total++; if (got !== 1'b1 || at !== r + 5) begin bad++; $display("FAIL rmid_after: got valid %b cycle %0d want 1 at %0d", got, at, r + 5); end
    total++; if (d !== 64'h0123_4567_89AB_CDEF || t !== 5'd25) begin bad++; $display("FAIL rmid_after_data: got %h/%0d want 0123456789abcdef/25", d, t); end
  endtask

  initial begin
    drive_idle();
    bus.mem_interlock = 1'b0;
    test_reset();
    test_store();
    idle(2);
    test_load_extend();
    idle(2);
    test_back_to_back();
    idle(4);
    test_fill();
    idle(2);
    test_misalign();
    idle(2);
    test_reset_midflight();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
